mem_rd_streamer: RTL and testbench



---
 rtl/mem_rd_streamer.sv | 130 +++++++++++++
 tb/tb_mem_rd_streamer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_streamer.sv
// Line-memory read engine: issues reads for a (start line, count) command and streams lines out as AXI-stream.
// Optional MEM_RD_STREAMER_BOUND_CHECK_EN rejects commands that would run past the top of memory.
module mem_rd_streamer #(
    parameter int BYTES_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 13,
    parameter int LINE_SIZE      = 8 * BYTES_PER_LINE,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  cmd_err,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LINE_SIZE-1:0]  mem_dout,
    output logic [LINE_SIZE-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q, len_q, emit_q;
    logic [1:0]            occ_q;
    logic                  wr_ptr_q, rd_ptr_q;
    logic                  vld_p1;
    logic                  cmd_err_q;
    logic [LINE_SIZE-1:0]  buf_q [2];
    logic                  cmd_fire, cmd_drop, pop, issue, head_last;
    logic [2:0]            credit_use;

    assign cmd_fire = cmd_valid && (state_q == IDLE);

`ifdef MEM_RD_STREAMER_BOUND_CHECK_EN
    localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
    logic [SUM_W-1:0] end_line;
    assign end_line = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign cmd_drop = end_line > (SUM_W'(1) << ADDR_WIDTH);
`else
    assign cmd_drop = 1'b0;
`endif

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign head_last     = ((emit_q + LEN_WIDTH'(1)) == len_q);
    assign m_axis_tlast  = m_axis_tvalid && head_last;
    // Gate data so the stream shows zero whenever nothing is buffered (including after reset).
    assign m_axis_tdata  = m_axis_tvalid ? buf_q[rd_ptr_q] : '0;

    // Buffered lines plus the read in flight, minus the beat leaving now, must leave room for one more.
    assign credit_use = 3'(occ_q) + 3'(vld_p1) - 3'(pop);
    assign issue      = (state_q == READ) && (credit_use < 3'd2);

    assign mem_addr  = addr_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cmd_err   = cmd_err_q;

    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && !cmd_drop && (cmd_len != '0))
                    state_d = READ;
            end
            READ: begin
                mem_en = issue;
                if (issue && (rem_q == LEN_WIDTH'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && head_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            emit_q    <= '0;
            occ_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            vld_p1    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_p1    <= mem_en;
            cmd_err_q <= cmd_fire && cmd_drop;
            if (cmd_fire) begin
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
                len_q  <= cmd_len;
                emit_q <= '0;
            end else begin
                if (mem_en) begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    rem_q  <= rem_q - LEN_WIDTH'(1);
                end
                if (pop)
                    emit_q <= emit_q + LEN_WIDTH'(1);
            end
            if (vld_p1)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + 2'(vld_p1) - 2'(pop);
        end
    end

    // Stage p1 -> buffer: capture memory data the cycle after its read was issued
    always_ff @(posedge clk) begin
        if (vld_p1)
            buf_q[wr_ptr_q] <= mem_dout;
    end

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Directed bench for mem_rd_streamer with a registered-read memory model and stream/issue logging.
module tb_mem_rd_streamer;
    localparam int AW = 13;
    localparam int LW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready, cmd_err, mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, busy;
    logic          m_axis_tready = 1'b1;

    mem_rd_streamer #(.BYTES_PER_LINE(4), .ADDR_WIDTH(AW), .LINE_SIZE(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: line a holds 0x5A000000 | a, one-cycle registered read
    always @(posedge clk) if (mem_en) mem_dout <= 32'h5A00_0000 | 32'(mem_addr);

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) m_axis_tready = 1'b1;
        else case (cyc % 4)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'b0;
            2: m_axis_tready = 1'b0;
            default: m_axis_tready = 1'b1;
        endcase
    end

    int            en_cyc[$];
    logic [AW-1:0] en_addr[$];
    int            bt_cyc[$];
    logic [DW-1:0] bt_data[$];
    logic          bt_last[$];
    int            err_cyc[$];
    int            outstanding = 0, max_out = 0, stall_viol = 0;
    bit            busy_seen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
                stall_viol++;
            if (mem_en) begin
                en_cyc.push_back(cyc);
                en_addr.push_back(mem_addr);
                outstanding++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                bt_cyc.push_back(cyc);
                bt_data.push_back(m_axis_tdata);
                bt_last.push_back(m_axis_tlast);
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (cmd_err) err_cyc.push_back(cyc);
            if (busy) busy_seen = 1;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        en_cyc.delete(); en_addr.delete();
        bt_cyc.delete(); bt_data.delete(); bt_last.delete();
        err_cyc.delete();
        outstanding = 0; max_out = 0; stall_viol = 0; busy_seen = 0;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n, output int t);
        @(posedge clk); #1;
        cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
        @(negedge clk);
        chk("cmd_ready_on_cmd", cmd_ready, 1);
        t = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("idle_timeout", 0, 1);
        idle_cyc = cyc;
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_cmd_ready"}, cmd_ready, 1);
        chk({p, "_cmd_err"}, cmd_err, 0);
        chk({p, "_mem_en"}, mem_en, 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_tdata"}, m_axis_tdata, 0);
        chk({p, "_tvalid"}, m_axis_tvalid, 0);
        chk({p, "_tlast"}, m_axis_tlast, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, idle, n;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic 4-line command, tready held high
        clear_logs();
        send_cmd(13'h010, 16'd4, t);
        wait_idle(50, idle);
        chk("t1_en_count", en_addr.size(), 4);
        for (int i = 0; i < 4 && i < en_addr.size(); i++) begin
            chk("t1_en_addr", en_addr[i], 64'(13'h010 + i));
            chk("t1_en_cyc", en_cyc[i], t + 1 + i);
        end
        chk("t1_beats", bt_data.size(), 4);
        for (int i = 0; i < 4 && i < bt_data.size(); i++) begin
            chk("t1_tdata", bt_data[i], 64'(32'h5A00_0010 + i));
            chk("t1_beat_cyc", bt_cyc[i], t + 3 + i);
            chk("t1_tlast", bt_last[i], (i == 3) ? 1 : 0);
        end
        chk("t1_ready_cyc", idle, t + 7);

        // 8 lines under a 1,0,0,1 tready pattern
        clear_logs();
        rdy_mode = 1;
        send_cmd(13'h100, 16'd8, t);
        wait_idle(200, idle);
        rdy_mode = 0;
        chk("t2_en_count", en_addr.size(), 8);
        chk("t2_beats", bt_data.size(), 8);
        for (int i = 0; i < 8 && i < bt_data.size(); i++) begin
            chk("t2_tdata", bt_data[i], 64'(32'h5A00_0100 + i));
            chk("t2_tlast", bt_last[i], (i == 7) ? 1 : 0);
        end
        chk("t2_stall_stable", stall_viol, 0);
        chk("t2_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);

        // Command crossing the top of memory
        clear_logs();
        send_cmd(13'h1FFE, 16'd4, t);
`ifdef MEM_RD_STREAMER_BOUND_CHECK_EN
        repeat (8) @(negedge clk);
        chk("t3_err_pulses", err_cyc.size(), 1);
        if (err_cyc.size() > 0) chk("t3_err_cyc", err_cyc[0], t + 1);
        chk("t3_no_en", en_addr.size(), 0);
        chk("t3_no_beats", bt_data.size(), 0);
        chk("t3_busy_seen", busy_seen, 0);
`else
        wait_idle(50, idle);
        chk("t3_en_count", en_addr.size(), 4);
        if (en_addr.size() == 4) begin
            chk("t3_addr0", en_addr[0], 13'h1FFE);
            chk("t3_addr1", en_addr[1], 13'h1FFF);
            chk("t3_addr2", en_addr[2], 13'h0000);
            chk("t3_addr3", en_addr[3], 13'h0001);
        end
        chk("t3_beats", bt_data.size(), 4);
        if (bt_data.size() == 4) begin
            chk("t3_tdata2", bt_data[2], 32'h5A00_0000);
            chk("t3_tdata3", bt_data[3], 32'h5A00_0001);
        end
        chk("t3_no_err", err_cyc.size(), 0);
`endif

        // Zero-length command, then a single line
        clear_logs();
        send_cmd(13'h005, 16'd0, t);
        wait_idle(10, idle);
        chk("t4_ready_cyc", idle, t + 1);
        repeat (4) @(negedge clk);
        chk("t4_no_en", en_addr.size(), 0);
        chk("t4_no_beats", bt_data.size(), 0);
        chk("t4_busy_seen", busy_seen, 0);
        send_cmd(13'h020, 16'd1, t);
        wait_idle(20, idle);
        chk("t4b_beats", bt_data.size(), 1);
        if (bt_data.size() == 1) begin
            chk("t4b_tdata", bt_data[0], 32'h5A00_0020);
            chk("t4b_tlast", bt_last[0], 1);
        end
        chk("t4b_ready_cyc", idle, t + 4);

        // Reset in the middle of a 16-line command
        clear_logs();
        send_cmd(13'h040, 16'd16, t);
        n = 0;
        while (bt_data.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_five_beats", bt_data.size(), 5);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("t5_rst");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_logs();
        send_cmd(13'h200, 16'd2, t);
        wait_idle(20, idle);
        repeat (4) @(negedge clk);
        chk("t5_en_count", en_addr.size(), 2);
        chk("t5_beats", bt_data.size(), 2);
        if (bt_data.size() == 2) begin
            chk("t5_tdata0", bt_data[0], 32'h5A00_0200);
            chk("t5_tdata1", bt_data[1], 32'h5A00_0201);
            chk("t5_tlast0", bt_last[0], 0);
            chk("t5_tlast1", bt_last[1], 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
